branch_predictor_gshare: RTL and testbench



---
 rtl/branch_predictor_gshare_pkg.sv | 27 ++
 rtl/branch_predictor_gshare_bht_table.sv | 48 ++++
 rtl/branch_predictor_gshare.sv | 102 ++++++++++
 tb/tb_branch_predictor_gshare.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types, constants and saturating-counter helpers for the branch predictor.
package bp_pkg;

  localparam int DATA_WID    = 32;
  localparam int PC_WORD_OFF = 2;
  localparam int CTR_W_MAX   = 4;

  // Wide enough for any legal counter width; callers truncate to CTR_BITS.
  typedef logic [CTR_W_MAX-1:0] ctr_t;

  function automatic ctr_t ctr_max(input int bits);
    return ctr_t'((1 << bits) - 1);
  endfunction

  function automatic ctr_t ctr_init(input int bits);
    return ctr_t'((1 << (bits - 1)) - 1);
  endfunction

  function automatic ctr_t sat_inc(input ctr_t v, input int bits);
    return (v >= ctr_max(bits)) ? v : v + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t v, input int bits);
    return (v == '0) ? v : v - ctr_t'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_bht_table.sv
// Branch history table: ENTRIES saturating counters, one combinational read
// port and one synchronous saturating-update port.
module bht_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int IDX      = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX-1:0]      rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                upd_en,
  input  logic [IDX-1:0]      upd_idx,
  input  logic                upd_taken
);

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  ctr_t                upd_cur;

  // Reads see the registered array only, so a same-cycle update is not bypassed.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ctr_d   = ctr_q;
    upd_cur = ctr_t'(ctr_q[upd_idx]);
    if (upd_en) begin
      ctr_d[upd_idx] = CTR_BITS'(upd_taken ? sat_inc(upd_cur, CTR_BITS)
                                           : sat_dec(upd_cur, CTR_BITS));
    end
  end

  // NOTE: the table must reset to weakly-not-taken, so this array is a
  // resettable flop bank rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_BITS'(ctr_init(CTR_BITS));
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// ID-stage gshare/bimodal branch predictor: index hashing, non-speculative
// global history, next-PC selection and resolution statistics.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch,
  input  logic                ujtype,
  input  logic                is_jalr,
  input  logic [DATA_WID-1:0] pc,
  input  logic [DATA_WID-1:0] imm,
  input  logic [DATA_WID-1:0] rs1_data,
  input  logic                old_branch,
  input  logic [DATA_WID-1:0] old_pc,
  input  logic                old_predict,
  input  logic                old_actual,
  input  logic [DATA_WID-1:0] old_branch_pc,
  output logic [DATA_WID-1:0] target_pc,
  output logic                predict_result,
  output logic                predict_fail,
  output logic [DATA_WID-1:0] stat_pred,
  output logic [DATA_WID-1:0] stat_miss
);

  localparam int IDX = $clog2(ENTRIES);
  // In bimodal mode the history register shrinks to one unused bit that stays 0.
  localparam int GW  = (GHR_BITS > 0) ? GHR_BITS : 1;

  logic [GW-1:0]       ghr_q, ghr_d;
  logic [DATA_WID-1:0] stat_pred_q, stat_pred_d;
  logic [DATA_WID-1:0] stat_miss_q, stat_miss_d;
  logic [IDX-1:0]      ghr_ext, rd_idx, upd_idx;
  logic [CTR_BITS-1:0] rd_ctr;

  assign ghr_ext = (GHR_BITS > 0) ? IDX'(ghr_q) : '0;
  assign rd_idx  = pc[IDX+PC_WORD_OFF-1:PC_WORD_OFF] ^ ghr_ext;
  assign upd_idx = old_pc[IDX+PC_WORD_OFF-1:PC_WORD_OFF] ^ ghr_ext;

  bht_table #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IDX      (IDX)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_ctr    (rd_ctr),
    .upd_en    (old_branch),
    .upd_idx   (upd_idx),
    .upd_taken (old_actual)
  );

  assign predict_result = branch & rd_ctr[CTR_BITS-1];
  assign predict_fail   = old_branch & (old_predict != old_actual);

  always_comb begin
    if (predict_fail) begin
      target_pc = old_actual ? old_branch_pc : old_pc + DATA_WID'(4);
    end else if (ujtype && is_jalr) begin
      target_pc = (rs1_data + imm) & ~DATA_WID'(1);
    end else if (ujtype || predict_result) begin
      target_pc = pc + imm;
    end else begin
      target_pc = pc + DATA_WID'(4);
    end
  end

  always_comb begin
    ghr_d       = ghr_q;
    stat_pred_d = stat_pred_q;
    stat_miss_d = stat_miss_q;
    if (old_branch) begin
      // Shifting in the resolved outcome drops the oldest bit by truncation.
      if (GHR_BITS > 0) ghr_d = GW'({ghr_q, old_actual});
      stat_pred_d = stat_pred_q + DATA_WID'(1);
      stat_miss_d = stat_miss_q + DATA_WID'(predict_fail);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q       <= '0;
      stat_pred_q <= '0;
      stat_miss_q <= '0;
    end else begin
      ghr_q       <= ghr_d;
      stat_pred_q <= stat_pred_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_pred = stat_pred_q;
  assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench: a bimodal and a gshare (GHR_BITS=4) predictor share one
// stimulus stream and are checked against an abstract per-instance model.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch = 1'b0, ujtype = 1'b0, is_jalr = 1'b0;
  logic [31:0] pc = '0, imm = '0, rs1_data = '0;
  logic        old_branch = 1'b0, old_predict = 1'b0, old_actual = 1'b0;
  logic [31:0] old_pc = '0, old_branch_pc = '0;

  logic [31:0] tgt   [2];
  logic        pred  [2];
  logic        fail  [2];
  logic [31:0] spred [2];
  logic [31:0] smiss [2];

  branch_predictor_gshare #(.ENTRIES(64), .CTR_BITS(2), .GHR_BITS(0)) u_bim (
    .clk(clk), .rst(rst), .branch(branch), .ujtype(ujtype), .is_jalr(is_jalr),
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .old_branch(old_branch),
    .old_pc(old_pc), .old_predict(old_predict), .old_actual(old_actual),
    .old_branch_pc(old_branch_pc), .target_pc(tgt[0]), .predict_result(pred[0]),
    .predict_fail(fail[0]), .stat_pred(spred[0]), .stat_miss(smiss[0])
  );

  branch_predictor_gshare #(.ENTRIES(64), .CTR_BITS(2), .GHR_BITS(4)) u_gsh (
    .clk(clk), .rst(rst), .branch(branch), .ujtype(ujtype), .is_jalr(is_jalr),
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .old_branch(old_branch),
    .old_pc(old_pc), .old_predict(old_predict), .old_actual(old_actual),
    .old_branch_pc(old_branch_pc), .target_pc(tgt[1]), .predict_result(pred[1]),
    .predict_fail(fail[1]), .stat_pred(spred[1]), .stat_miss(smiss[1])
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        branch, ujtype, is_jalr;
    logic [31:0] pc, imm, rs1;
    logic        ob;
    logic [31:0] opc;
    logic        opred, oact;
    logic [31:0] obpc;
  } stim_t;

  typedef struct packed {
    logic        inst;
    logic [31:0] tgt;
    logic        pred, fail;
    logic [31:0] sp, sm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: counters as plain integers, history as an integer word.
  int          ctr_m [2][64];
  int          ghr_m [2];
  int unsigned sp_m  [2];
  int unsigned sm_m  [2];
  int          ghr_len [2] = '{0, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) ctr_m[k][i] = 1;
      ghr_m[k] = 0;
      sp_m[k]  = 0;
      sm_m[k]  = 0;
    end
  endtask

  function automatic int idx_of(input int k, input logic [31:0] a);
    return (int'(a[7:2]) ^ ghr_m[k]) % 64;
  endfunction

  function automatic logic model_pred(input int k, input logic [31:0] a);
    return ctr_m[k][idx_of(k, a)] >= 2;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    logic p, f;
    int   oi;
    @(posedge clk);
    #1;
    branch = s.branch; ujtype = s.ujtype; is_jalr = s.is_jalr;
    pc = s.pc; imm = s.imm; rs1_data = s.rs1;
    old_branch = s.ob; old_pc = s.opc; old_predict = s.opred;
    old_actual = s.oact; old_branch_pc = s.obpc;
    for (int k = 0; k < 2; k++) begin
      p = s.branch && model_pred(k, s.pc);
      f = s.ob && (s.opred != s.oact);
      e.inst = 1'(k);
      e.pred = p;
      e.fail = f;
      e.sp   = sp_m[k];
      e.sm   = sm_m[k];
      if (f)                         e.tgt = s.oact ? s.obpc : s.opc + 32'd4;
      else if (s.ujtype && s.is_jalr) e.tgt = (s.rs1 + s.imm) & 32'hFFFF_FFFE;
      else if (s.ujtype || p)        e.tgt = s.pc + s.imm;
      else                           e.tgt = s.pc + 32'd4;
      q.push_back(e);
      if (s.ob) begin
        oi = idx_of(k, s.opc);
        ctr_m[k][oi] = s.oact ? ((ctr_m[k][oi] < 3) ? ctr_m[k][oi] + 1 : 3)
                              : ((ctr_m[k][oi] > 0) ? ctr_m[k][oi] - 1 : 0);
        if (ghr_len[k] > 0) ghr_m[k] = ((ghr_m[k] << 1) | int'(s.oact)) % (1 << ghr_len[k]);
        sp_m[k] = sp_m[k] + 1;
        if (f) sm_m[k] = sm_m[k] + 1;
      end
    end
  endtask

  // Monitor: outputs are combinational, so every issued cycle is compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("target_pc[%0d]", e.inst), tgt[e.inst], e.tgt);
      check($sformatf("predict_result[%0d]", e.inst), 32'(pred[e.inst]), 32'(e.pred));
      check($sformatf("predict_fail[%0d]", e.inst), 32'(fail[e.inst]), 32'(e.fail));
      check($sformatf("stat_pred[%0d]", e.inst), spred[e.inst], e.sp);
      check($sformatf("stat_miss[%0d]", e.inst), smiss[e.inst], e.sm);
    end
  end

  function automatic stim_t lookup(input logic [31:0] a, input logic [31:0] im);
    stim_t s = '0;
    s.branch = 1'b1; s.pc = a; s.imm = im;
    return s;
  endfunction

  function automatic stim_t update(input logic [31:0] a, input logic pr, input logic ac);
    stim_t s = '0;
    s.ob = 1'b1; s.opc = a; s.opred = pr; s.oact = ac; s.obpc = 32'h500;
    return s;
  endfunction

  // Alternating T/N branch at one PC, each lookup resolved before the next.
  task automatic alt_pattern(input int k, input int exp_miss);
    stim_t s;
    logic  p;
    logic [31:0] m0;
    for (int i = 0; i < 24; i++) begin
      if (i == 16) begin
        drive('0);
        m0 = smiss[k];
      end
      p = model_pred(k, 32'h410);
      drive(lookup(32'h410, 32'h40));
      s = update(32'h410, p, (i % 2) == 0);
      drive(s);
    end
    drive('0);
    check($sformatf("alt_miss_window[%0d]", k), smiss[k] - m0, 32'(exp_miss));
  endtask

  initial begin
    stim_t s;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_target[%0d]", k), tgt[k], 32'h4);
      check($sformatf("rst_pred[%0d]", k), 32'(pred[k]), 32'h0);
      check($sformatf("rst_fail[%0d]", k), 32'(fail[k]), 32'h0);
      check($sformatf("rst_stat_pred[%0d]", k), spred[k], 32'h0);
    end
    #11 rst = 1'b1;

    // Defaults, then train taken twice with mispredicts and look up again.
    drive(lookup(32'h100, 32'h20));
    drive(update(32'h100, 1'b0, 1'b1));
    drive(update(32'h100, 1'b0, 1'b1));
    drive(lookup(32'h100, 32'h20));

    // Saturation: five taken, then not-taken steps at a fresh index.
    for (int i = 0; i < 5; i++) drive(update(32'h208, model_pred(0, 32'h208), 1'b1));
    drive(update(32'h208, 1'b1, 1'b0));
    drive(lookup(32'h208, 32'h80));
    drive(update(32'h208, 1'b1, 1'b0));
    drive(lookup(32'h208, 32'h80));

    // Jumps leave stats and table untouched.
    s = '0; s.ujtype = 1'b1; s.is_jalr = 1'b1; s.rs1 = 32'h2001; s.imm = 32'h10;
    drive(s);
    s = '0; s.ujtype = 1'b1; s.pc = 32'h40; s.imm = 32'hFFFF_FFF8;
    drive(s);

    // Correction outranks a concurrent jump, for taken and not-taken fixes.
    s = update(32'h600, 1'b0, 1'b1); s.ujtype = 1'b1; s.pc = 32'h40; s.imm = 32'h100;
    s.obpc = 32'h700;
    drive(s);
    s = update(32'h600, 1'b1, 1'b0); s.ujtype = 1'b1; s.is_jalr = 1'b1; s.rs1 = 32'h3000;
    drive(s);

    // Same-index lookup during update reads the pre-update counter.
    for (int i = 0; i < 3; i++) begin
      s = update(32'h30C, model_pred(0, 32'h30C), 1'b1);
      s.branch = 1'b1; s.pc = 32'h30C; s.imm = 32'h24;
      drive(s);
    end

    alt_pattern(1, 0);

    // Asynchronous reset mid-update, away from any clock edge.
    drive(update(32'h100, 1'b0, 1'b1));
    @(negedge clk);
    #2;
    rst = 1'b0;
    branch = 1'b1; pc = 32'h30C; imm = 32'h24; old_branch = 1'b0; ujtype = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_rst_stat_pred[%0d]", k), spred[k], 32'h0);
      check($sformatf("async_rst_stat_miss[%0d]", k), smiss[k], 32'h0);
      check($sformatf("async_rst_pred[%0d]", k), 32'(pred[k]), 32'h0);
      check($sformatf("async_rst_target[%0d]", k), tgt[k], 32'h310);
    end
    old_branch = 1'b1; old_pc = 32'h30C; old_actual = 1'b1; old_predict = 1'b0;
    @(posedge clk);
    #1;
    check("rst_low_update_dropped", spred[0], 32'h0);
    old_branch = 1'b0;
    #2 rst = 1'b1;
    model_reset();

    alt_pattern(0, 8);

    // Randomized traffic over a small PC set to provoke index collisions.
    for (int i = 0; i < 300; i++) begin
      s.branch  = 1'($urandom_range(0, 1));
      s.ujtype  = ($urandom_range(0, 5) == 0);
      s.is_jalr = 1'($urandom_range(0, 1));
      s.pc      = 32'h100 + 32'($urandom_range(0, 15) << 2);
      s.imm     = $urandom;
      s.rs1     = $urandom;
      s.ob      = 1'($urandom_range(0, 1));
      s.opc     = 32'h100 + 32'($urandom_range(0, 15) << 2);
      s.opred   = 1'($urandom_range(0, 1));
      s.oact    = 1'($urandom_range(0, 1));
      s.obpc    = $urandom;
      drive(s);
    end
    drive('0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
